// File: rtl/fifo_word_packer.sv
// fifo_word_packer: read-domain consumer of the async FIFO. Pops WIDTH-bit
// entries and packs LANES of them little-endian into one word, which is
// presented downstream with a valid/ready handshake.
// Optional partial-word flush after FLUSH_CYCLES idle cycles: define PACK_FLUSH_EN.
module fifo_word_packer #(
    parameter int WIDTH        = 8,
    parameter int LANES        = 4,
    parameter int FLUSH_CYCLES = 16
) (
    input  logic                       rdclk,
    input  logic                       reset,
    input  logic                       empty,
    input  logic [WIDTH-1:0]           fifo_data,
    output logic                       re,
    output logic [WIDTH*LANES-1:0]     word_out,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic [$clog2(LANES):0]     word_bytes
);

    localparam int CW = $clog2(LANES) + 1;
    localparam logic [CW-1:0] LANES_C = CW'(LANES);

    if (LANES < 2 || FLUSH_CYCLES < 1) begin : g_param_check
        $error("fifo_word_packer: LANES must be >= 2 and FLUSH_CYCLES >= 1");
    end

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          commit;
    logic                   pend_q, pend_d;
    logic [WIDTH*LANES-1:0] asm_q, asm_d, asm_cap;
    logic [WIDTH*LANES-1:0] word_out_q, word_out_d;
    logic [CW-1:0]          word_bytes_q, word_bytes_d;
    logic                   word_valid_q, word_valid_d;
    logic                   out_free;
    logic                   flush;
    logic                   re_c;

`ifdef PACK_FLUSH_EN
    localparam int IW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [IW-1:0] FLUSH_C = IW'(FLUSH_CYCLES);

    logic [IW-1:0] idle_q, idle_d;

    // Idle timer for a partially filled word; saturates at FLUSH_CYCLES.
    always_comb begin
        flush = (state_q == FILL) && !pend_q && (cnt_q != '0) &&
                (cnt_q < LANES_C) && (idle_q == FLUSH_C) &&
                (!word_valid_q || word_ready);
        idle_d = idle_q;
        if (pend_q || (cnt_q == '0) || flush) begin
            idle_d = '0;
        end else if (empty && (state_q == FILL) && (cnt_q < LANES_C) &&
                     (idle_q != FLUSH_C)) begin
            idle_d = idle_q + 1'b1;
        end
    end

    // Idle timer register.
    always_ff @(posedge rdclk or posedge reset) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    // Partial words wait indefinitely for more data.
    always_comb begin
        flush = 1'b0;
    end
`endif

    // Capture, word completion, HOLD handling, output handshake and read issue.
    // A word completes in the cycle its last lane is captured, so the capture
    // and the transfer to the output register share that cycle; this keeps
    // reads back-to-back when the output register can take the word.
    always_comb begin
        commit   = cnt_q + CW'(pend_q);
        out_free = ~word_valid_q | word_ready;

        asm_cap = asm_q;
        if (pend_q) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (cnt_q == CW'(i)) begin
                    asm_cap[i*WIDTH +: WIDTH] = fifo_data;
                end
            end
        end

        state_d      = state_q;
        cnt_d        = commit;
        asm_d        = asm_cap;
        word_valid_d = word_valid_q & ~word_ready;
        word_out_d   = word_out_q;
        word_bytes_d = word_bytes_q;
        re_c         = 1'b0;

        case (state_q)
            FILL: begin
                if (commit == LANES_C) begin
                    if (out_free) begin
                        word_out_d   = asm_cap;
                        word_bytes_d = LANES_C;
                        word_valid_d = 1'b1;
                        cnt_d        = '0;
                        asm_d        = '0;
                    end else begin
                        state_d = HOLD;
                    end
                end else if (flush) begin
                    word_out_d   = asm_q;
                    word_bytes_d = cnt_q;
                    word_valid_d = 1'b1;
                    cnt_d        = '0;
                    asm_d        = '0;
                end
                re_c = ~empty & ~flush &
                       ((commit < LANES_C) | ((commit == LANES_C) & out_free));
            end
            HOLD: begin
                if (word_valid_q && word_ready) begin
                    word_out_d   = asm_q;
                    word_bytes_d = LANES_C;
                    word_valid_d = 1'b1;
                    cnt_d        = '0;
                    asm_d        = '0;
                    state_d      = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        pend_d = re_c;
    end

    // State, assembly and output registers.
    always_ff @(posedge rdclk or posedge reset) begin
        if (reset) begin
            state_q      <= FILL;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            asm_q        <= '0;
            word_out_q   <= '0;
            word_bytes_q <= '0;
            word_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            asm_q        <= asm_d;
            word_out_q   <= word_out_d;
            word_bytes_q <= word_bytes_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign re         = re_c;
    assign word_out   = word_out_q;
    assign word_bytes = word_bytes_q;
    assign word_valid = word_valid_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer: scoreboard bench for fifo_word_packer with a
// behavioural FIFO model; expected words are grouped from pushed entries.
module tb_fifo_word_packer;

    localparam int W  = 8;
    localparam int L  = 4;
    localparam int FC = 16;
    localparam int BW = 3;

    logic             rdclk = 1'b0;
    logic             reset;
    logic             empty;
    logic [W-1:0]     fifo_data;
    logic             re;
    logic [W*L-1:0]   word_out;
    logic             word_valid;
    logic             word_ready;
    logic [BW-1:0]    word_bytes;

    always #5 rdclk = ~rdclk;

    fifo_word_packer #(.WIDTH(W), .LANES(L), .FLUSH_CYCLES(FC)) dut (
        .rdclk      (rdclk),
        .reset      (reset),
        .empty      (empty),
        .fifo_data  (fifo_data),
        .re         (re),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_bytes (word_bytes)
    );

    int errors = 0;
    int checks = 0;
    int pushed = 0;
    int popped = 0;

    logic [W-1:0]   fifo_q[$];
    logic [W*L-1:0] exp_w[$];
    logic [BW-1:0]  exp_b[$];
    logic [W*L-1:0] grp_word = '0;
    int             grp_n = 0;

    int rdy_mode = 0;   // 0: fixed level, 1: toggle, 2: random
    bit rdy_fix  = 1'b0;
    bit in_reset = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Entry into the FIFO model; every LANES entries form one expected word.
    task automatic push_entry(input logic [W-1:0] b);
        fifo_q.push_back(b);
        pushed++;
        grp_word[grp_n*W +: W] = b;
        grp_n++;
        if (grp_n == L) begin
            exp_w.push_back(grp_word);
            exp_b.push_back(BW'(L));
            grp_word = '0;
            grp_n    = 0;
        end
    endtask

    task automatic drop_partial();
        grp_word = '0;
        grp_n    = 0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_w.size() != 0 || word_valid) && n < budget) begin
            @(negedge rdclk);
            n++;
        end
        check("drain_done", exp_w.size(), 0);
    endtask

    // FIFO read side: re sampled mid-cycle, data appears just after the edge.
    initial begin
        bit pop_now;
        empty     = 1'b1;
        fifo_data = '0;
        forever begin
            @(negedge rdclk);
            pop_now = re && !empty;
            @(posedge rdclk);
            pop_now = pop_now && !reset;
            #1;
            if (pop_now && fifo_q.size() > 0) begin
                fifo_data = fifo_q.pop_front();
                popped++;
            end
            empty = (fifo_q.size() == 0);
        end
    end

    // Downstream ready driver.
    initial begin
        word_ready = 1'b0;
        forever begin
            @(posedge rdclk);
            #1;
            case (rdy_mode)
                0:       word_ready = rdy_fix;
                1:       word_ready = ~word_ready;
                default: word_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: scoreboard pop on acceptance, stability while stalled, no read while empty.
    initial begin
        logic           pv, pr;
        logic [W*L-1:0] pw, ew;
        logic [BW-1:0]  pb, eb;
        pv = 1'b0; pr = 1'b0; pw = '0; pb = '0;
        forever begin
            @(negedge rdclk);
            if (in_reset) begin
                pv = 1'b0;
            end else begin
                if (empty) check("re_while_empty", re, 0);
                if (pv && !pr) begin
                    check("hold_valid", word_valid, 1);
                    check("hold_word", word_out, pw);
                    check("hold_bytes", word_bytes, pb);
                end
                if (word_valid && word_ready) begin
                    checks++;
                    if (exp_w.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_word: got %0h expected none", word_out);
                    end else begin
                        ew = exp_w.pop_front();
                        eb = exp_b.pop_front();
                        checks--;
                        check("word_out", word_out, ew);
                        check("word_bytes", word_bytes, eb);
                    end
                end
                pv = word_valid; pr = word_ready; pw = word_out; pb = word_bytes;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_re, last_re, re_cnt, p0;

        reset = 1'b1;
        repeat (3) @(negedge rdclk);
        check("rst_re", re, 0);
        check("rst_valid", word_valid, 0);
        check("rst_word", word_out, 0);
        check("rst_bytes", word_bytes, 0);
        reset = 1'b0;
        @(negedge rdclk);
        in_reset = 1'b0;

        // Empty FIFO: no reads, no words.
        for (int i = 0; i < 30; i++) begin
            @(negedge rdclk);
            check("t4_re", re, 0);
            check("t4_valid", word_valid, 0);
        end

        // 8 entries, ready high: 8 back-to-back reads, two words.
        rdy_fix = 1'b1;
        @(negedge rdclk);
        for (int i = 1; i <= 8; i++) push_entry(W'(8'h11 * i));
        first_re = -1; last_re = -1; re_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge rdclk);
            if (re) begin
                if (first_re < 0) first_re = i;
                last_re = i;
                re_cnt++;
            end
        end
        check("t2_re_count", re_cnt, 8);
        check("t2_re_span", last_re - first_re, 7);
        drain(100);

        // 12 entries with ready low: one word out, one in HOLD, reads stop at 8.
        rdy_fix = 1'b0;
        @(negedge rdclk);
        p0 = popped;
        for (int i = 1; i <= 12; i++) push_entry(W'(i));
        repeat (22) @(negedge rdclk);
        check("t3_popped", popped - p0, 8);
        check("t3_re_idle", re, 0);
        check("t3_valid", word_valid, 1);
        check("t3_first_word", word_out, 32'h04030201);
        rdy_fix = 1'b1;
        drain(100);

        // Ready toggling every cycle while streaming 16 entries.
        rdy_mode = 1;
        for (int i = 0; i < 16; i++) push_entry(W'($urandom));
        drain(300);
        rdy_mode = 0;
        rdy_fix  = 1'b1;
        repeat (2) @(negedge rdclk);

        // Three entries then idle.
        push_entry(8'hA1);
        push_entry(8'hB2);
        push_entry(8'hC3);
`ifdef PACK_FLUSH_EN
        exp_w.push_back(grp_word);
        exp_b.push_back(BW'(grp_n));
        drop_partial();
        drain(100);
`else
        for (int i = 0; i < 40; i++) begin
            @(negedge rdclk);
            check("t5_no_flush", word_valid, 0);
        end
        in_reset = 1'b1;
        reset = 1'b1;
        @(negedge rdclk);
        reset = 1'b0;
        drop_partial();
        @(negedge rdclk);
        in_reset = 1'b0;
`endif

        // Reset mid-cycle with two lanes filled; next word restarts at lane 0.
        push_entry(8'hE1);
        push_entry(8'hE2);
        repeat (6) @(negedge rdclk);
        in_reset = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("t1_re", re, 0);
        check("t1_valid", word_valid, 0);
        check("t1_word", word_out, 0);
        check("t1_bytes", word_bytes, 0);
        drop_partial();
        @(negedge rdclk);
        reset = 1'b0;
        @(negedge rdclk);
        in_reset = 1'b0;
        push_entry(8'h5A);
        push_entry(8'h6B);
        push_entry(8'h7C);
        push_entry(8'h8D);
        drain(100);

        // Random bursts of whole words with random ready.
        rdy_mode = 2;
        for (int b = 0; b < 25; b++) begin
            for (int i = 0; i < L; i++) push_entry(W'($urandom));
            repeat ($urandom_range(0, 8)) @(negedge rdclk);
        end
        drain(2000);
        rdy_mode = 0;

        check("all_popped", popped, pushed);
        check("fifo_empty", fifo_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
